// File: rtl/c499_key_sequencer.sv
// Sequencer for the key-locked c499 SEC core: serial key load, then one
// (data, check) word at a time through the core with a settle interval.
module c499_key_sequencer #(
    parameter int KEY_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load_start,
    input  logic             key_bit,
    input  logic             key_bit_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    input  logic [7:0]       req_check,
    output logic [31:0]      core_data,
    output logic [7:0]       core_check,
    output logic             core_en,
    input  logic [31:0]      core_corr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             busy
);

    localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int CW = $clog2(KEY_W + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        APPLY,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             key_ready_q, key_ready_d;
    logic [31:0]      core_data_q, core_data_d;
    logic [7:0]       core_check_q, core_check_d;
    logic             core_en_q, core_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        key_ready_d  = key_ready_q;
        core_data_d  = core_data_q;
        core_check_d = core_check_q;
        core_en_d    = core_en_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;

        // A load start aborts anything in flight and wins over key_bit_valid
        if (key_load_start) begin
            state_d     = LOAD;
            key_d       = '0;
            cnt_d       = '0;
            key_ready_d = 1'b0;
            core_en_d   = 1'b0;
            rsp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (key_bit_valid) begin
                        key_d[cnt_q[IW-1:0]] = key_bit;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(KEY_W - 1)) begin
                            state_d     = READY;
                            key_ready_d = 1'b1;
                        end
                    end
                end
                READY: begin
                    if (req_valid) begin
                        core_data_d  = req_data;
                        core_check_d = req_check;
                        core_en_d    = 1'b1;
                        settle_d     = SW'(SETTLE - 1);
                        state_d      = APPLY;
                    end
                end
                APPLY: begin
                    if (settle_q == '0) begin
                        rsp_data_d  = core_corr;
                        rsp_valid_d = 1'b1;
                        core_en_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        state_d     = READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            key_q        <= '0;
            cnt_q        <= '0;
            settle_q     <= '0;
            key_ready_q  <= 1'b0;
            core_data_q  <= '0;
            core_check_q <= '0;
            core_en_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            key_ready_q  <= key_ready_d;
            core_data_q  <= core_data_d;
            core_check_q <= core_check_d;
            core_en_q    <= core_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign key_out    = key_q;
    assign core_data  = core_data_q;
    assign core_check = core_check_q;
    assign core_en    = core_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign req_ready  = (state_q == READY);
    assign busy       = (state_q == LOAD) || (state_q == APPLY) ||
                        (state_q == RESP);

endmodule
